// File: rtl/fill_pkg.sv
// Shared encodings for the pill-bottling fill sequencer.
package fill_pkg;

  // Width of one BCD digit.
  localparam int BCD_W = 4;

  // The state encoding drives the status digit and beeper, so the values are fixed.
  typedef enum logic [2:0] {
    ST_SETTING   = 3'd0,
    ST_RUNNING   = 3'd1,
    ST_SWITCHING = 3'd2,
    ST_DONE      = 3'd3,
    ST_ERROR     = 3'd4,
    ST_FATAL     = 3'd5
  } fill_state_e;

  // Error codes reported while in ERROR.
  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_HOPPER   = 2'd1;
  localparam logic [1:0] ERR_CONVEYOR = 2'd2;

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit counter (0..9) with clear, increment and carry to the next digit.
module bcd_digit
  import fill_pkg::*;
(
  input  logic             clk_1khz,
  input  logic             switch_clr,
  input  logic             inc,
  input  logic             clr,
  output logic [BCD_W-1:0] q,
  output logic [BCD_W-1:0] q_succ,
  output logic             carry_out
);

  logic [BCD_W-1:0] q_next;

  // Successor of the current digit (9 wraps to 0) and the registered next value; clear wins.
  always_comb begin
    q_succ    = (q == 4'd9) ? '0 : q + 4'd1;
    carry_out = inc && (q == 4'd9);
    q_next    = q;
    if (clr) begin
      q_next = '0;
    end else if (inc) begin
      q_next = q_succ;
    end
  end

  // Digit register.
  always_ff @(posedge clk_1khz or negedge switch_clr) begin
    if (!switch_clr) begin
      q <= '0;
    end else begin
      q <= q_next;
    end
  end

endmodule

// File: rtl/fill_sequencer.sv
// Fill sequencer: counts pills into bottles, times conveyor switch-over and
// hopper starvation, and handles error, done and e-stop recovery.
// Strobe handshake: pill_pulse, tick_1s, start and ack are single-cycle
// strobes; each is consumed on the clock edge where it is high, there is no
// ready/back-pressure, and a strobe arriving in a state that ignores it is lost.
module fill_sequencer
  import fill_pkg::*;
#(
  parameter int HOP_TIMEOUT = 5,
  parameter int SWITCH_SEC  = 2,
  parameter int TW          = 4
) (
  input  logic        clk_1khz,
  input  logic        switch_clr,
  input  logic        tick_1s,
  input  logic        pill_pulse,
  input  logic        conveyor_ok,
  input  logic        estop,
  input  logic        start,
  input  logic        ack,
  input  logic [11:0] tgt_pills,
  input  logic [7:0]  tgt_bottles,
  output logic [2:0]  state,
  output logic [11:0] now_pills,
  output logic [7:0]  now_bottles,
  output logic [1:0]  err_code,
  output logic        hopper_en,
  output logic        conveyor_en,
  output logic        done_pulse
);

  localparam logic [TW-1:0] HOP_RELOAD = TW'(HOP_TIMEOUT);
  localparam logic [TW-1:0] SW_RELOAD  = TW'(SWITCH_SEC);
  localparam logic [TW-1:0] TIMER_ONE  = TW'(1);

  fill_state_e   state_r, state_n;
  logic [TW-1:0] hop_r, hop_n;
  logic [TW-1:0] sw_r, sw_n;
  logic [1:0]    err_r, err_n;
  logic [11:0]   tp_r, tp_n;
  logic [7:0]    tb_r, tb_n;
  logic          hopper_en_r, conveyor_en_r, done_r, done_n;
  logic          pill_inc, pill_clr, bot_inc, bot_clr, take_pill;

  // Digit chains: pills (3 digits) and completed bottles (2 digits).
  logic [3:0] p0_q, p1_q, p2_q, p0_s, p1_s, p2_s;
  logic       p0_cy, p1_cy, p2_cy;
  logic [3:0] b0_q, b1_q, b0_s, b1_s;
  logic       b0_cy, b1_cy;
  logic [11:0] pills_succ;
  logic [7:0]  bots_succ;

  bcd_digit u_p0 (.clk_1khz(clk_1khz), .switch_clr(switch_clr), .inc(pill_inc), .clr(pill_clr),
                  .q(p0_q), .q_succ(p0_s), .carry_out(p0_cy));
  bcd_digit u_p1 (.clk_1khz(clk_1khz), .switch_clr(switch_clr), .inc(p0_cy), .clr(pill_clr),
                  .q(p1_q), .q_succ(p1_s), .carry_out(p1_cy));
  bcd_digit u_p2 (.clk_1khz(clk_1khz), .switch_clr(switch_clr), .inc(p1_cy), .clr(pill_clr),
                  .q(p2_q), .q_succ(p2_s), .carry_out(p2_cy));
  bcd_digit u_b0 (.clk_1khz(clk_1khz), .switch_clr(switch_clr), .inc(bot_inc), .clr(bot_clr),
                  .q(b0_q), .q_succ(b0_s), .carry_out(b0_cy));
  bcd_digit u_b1 (.clk_1khz(clk_1khz), .switch_clr(switch_clr), .inc(b0_cy), .clr(bot_clr),
                  .q(b1_q), .q_succ(b1_s), .carry_out(b1_cy));

  // Value each count would take after one increment, built from registers only
  // so the target comparison does not loop back through the increment enables.
  // The top-digit carries (p2_cy, b1_cy) are unused: 999 and 99 simply wrap.
  assign pills_succ = {(p0_q == 4'd9 && p1_q == 4'd9) ? p2_s : p2_q,
                       (p0_q == 4'd9) ? p1_s : p1_q,
                       p0_s};
  assign bots_succ  = {(b0_q == 4'd9) ? b1_s : b1_q, b0_s};

  // Next-state, timer, error and counter-control decode; estop > ack > pill > tick.
  always_comb begin
    state_n   = state_r;
    hop_n     = hop_r;
    sw_n      = sw_r;
    err_n     = err_r;
    tp_n      = tp_r;
    tb_n      = tb_r;
    done_n    = 1'b0;
    pill_inc  = 1'b0;
    pill_clr  = 1'b0;
    bot_inc   = 1'b0;
    bot_clr   = 1'b0;
    take_pill = 1'b0;
    if (estop) begin
      state_n = ST_FATAL;
    end else begin
      unique case (state_r)
        ST_SETTING: begin
          if (start && tgt_pills != 12'd0 && tgt_bottles != 8'd0) begin
            tp_n     = tgt_pills;
            tb_n     = tgt_bottles;
            pill_clr = 1'b1;
            bot_clr  = 1'b1;
            hop_n    = HOP_RELOAD;
            state_n  = ST_RUNNING;
          end
        end
        ST_RUNNING: begin
          if (pill_pulse) begin
            take_pill = 1'b1;
          end else if (tick_1s) begin
            if (hop_r <= TIMER_ONE) begin
              hop_n   = '0;
              err_n   = ERR_HOPPER;
              state_n = ST_ERROR;
            end else begin
              hop_n = hop_r - TIMER_ONE;
            end
          end
        end
        ST_SWITCHING: begin
          if (tick_1s) begin
            if (sw_r <= TIMER_ONE) begin
              sw_n = '0;
              if (conveyor_ok) begin
                pill_clr = 1'b1;
                hop_n    = HOP_RELOAD;
                state_n  = ST_RUNNING;
              end else begin
                err_n   = ERR_CONVEYOR;
                state_n = ST_ERROR;
              end
            end else begin
              sw_n = sw_r - TIMER_ONE;
            end
          end
        end
        ST_ERROR: begin
          if (ack) begin
            err_n   = ERR_NONE;
            state_n = ST_SETTING;
          end else if (err_r == ERR_HOPPER && pill_pulse) begin
            err_n     = ERR_NONE;
            take_pill = 1'b1;
          end else if (err_r == ERR_CONVEYOR && conveyor_ok) begin
            err_n    = ERR_NONE;
            pill_clr = 1'b1;
            hop_n    = HOP_RELOAD;
            state_n  = ST_RUNNING;
          end
        end
        ST_DONE: begin
          if (ack) begin
            state_n = ST_SETTING;
          end
        end
        ST_FATAL: begin
          if (ack) begin
            pill_clr = 1'b1;
            bot_clr  = 1'b1;
            err_n    = ERR_NONE;
            hop_n    = '0;
            sw_n     = '0;
            state_n  = ST_SETTING;
          end
        end
        default: begin
          state_n = ST_SETTING;
        end
      endcase

      // A counted pill may complete the bottle and the whole run in the same cycle.
      if (take_pill) begin
        pill_inc = 1'b1;
        hop_n    = HOP_RELOAD;
        state_n  = ST_RUNNING;
        if (pills_succ == tp_r) begin
          bot_inc = 1'b1;
          if (bots_succ == tb_r) begin
            done_n  = 1'b1;
            state_n = ST_DONE;
          end else begin
            sw_n    = SW_RELOAD;
            state_n = ST_SWITCHING;
          end
        end
      end
    end
  end

  // State, timers, latched targets and registered enables.
  always_ff @(posedge clk_1khz or negedge switch_clr) begin
    if (!switch_clr) begin
      state_r       <= ST_SETTING;
      hop_r         <= '0;
      sw_r          <= '0;
      err_r         <= ERR_NONE;
      tp_r          <= '0;
      tb_r          <= '0;
      hopper_en_r   <= 1'b0;
      conveyor_en_r <= 1'b0;
      done_r        <= 1'b0;
    end else begin
      state_r       <= state_n;
      hop_r         <= hop_n;
      sw_r          <= sw_n;
      err_r         <= err_n;
      tp_r          <= tp_n;
      tb_r          <= tb_n;
      hopper_en_r   <= (state_n == ST_RUNNING);
      conveyor_en_r <= (state_n == ST_SWITCHING);
      done_r        <= done_n;
    end
  end

  assign state       = state_r;
  assign now_pills   = {p2_q, p1_q, p0_q};
  assign now_bottles = {b1_q, b0_q};
  assign err_code    = err_r;
  assign hopper_en   = hopper_en_r;
  assign conveyor_en = conveyor_en_r;
  assign done_pulse  = done_r;

endmodule
